operand_stage: RTL and testbench

//  Stage directly upstream of the ALU. Holds the 32-entry register file, reads rs/rt, sign-extends imm16, selects
//  the second operand (ALUSrc mux), decodes aluOp/funct into the 4-bit ALU control code, and registers all ALU

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/operand_stage_if.sv | 38 +++
 rtl/reg_file_2r1w.sv | 32 +++
 rtl/operand_stage.sv | 63 ++++++
 tb/tb_operand_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU control codes, aluOp/funct encodings and the aluOp/funct decoder shared
// by the operand stage and the downstream ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  typedef struct packed {
    logic      illegal;
    alu_ctrl_e code;
  } alu_dec_t;

  // Unsupported encodings fall back to ADD and raise the illegal flag.
  function automatic alu_dec_t alu_decode(input aluop_e op, input logic [5:0] funct);
    alu_dec_t d;
    d.illegal = 1'b0;
    d.code    = ALU_ADD;
    case (op)
      ALUOP_MEM: d.code = ALU_ADD;
      ALUOP_BEQ: d.code = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: d.code = ALU_ADD;
          FUNCT_SUB: d.code = ALU_SUB;
          FUNCT_AND: d.code = ALU_AND;
          FUNCT_OR:  d.code = ALU_OR;
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Instruction/writeback inputs and registered ALU operand outputs of operand_stage.
interface operand_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
);
  localparam int unsigned AW = $clog2(NREGS);

  logic              instrValid;
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic [15:0]       imm16;
  logic [1:0]        aluOp;
  logic              aluSrc;
  logic              stall;
  logic              flush;
  logic              regWrite;
  logic [AW-1:0]     writeReg;
  logic [DATA_W-1:0] writeData;

  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] saidaMusReg;
  logic [3:0]        aluControlOut;
  logic              opValid;
  logic              illegalOp;

  modport master (
    output instrValid, rs, rt, imm16, aluOp, aluSrc, stall, flush,
           regWrite, writeReg, writeData,
    input  readData1, readData2, saidaMusReg, aluControlOut, opValid, illegalOp
  );

  modport slave (
    input  instrValid, rs, rt, imm16, aluOp, aluSrc, stall, flush,
           regWrite, writeReg, writeData,
    output readData1, readData2, saidaMusReg, aluControlOut, opValid, illegalOp
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// NREGS x DATA_W register file: two async read ports, one sync write port,
// synchronous clear, register 0 hard-wired to zero.
module reg_file_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/operand_stage.sv
// Stage ahead of the ALU: register file read with writeback bypass, imm16
// sign extension, ALUSrc mux, ALU control decode and the ALU input register.
module operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input logic            clk,
  input logic            rst_n,
  operand_stage_if.slave bus
);

  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] op_a, op_b, imm_ext, mux_b;
  logic              byp_a, byp_b;
  alu_dec_t          dec;

  reg_file_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (bus.rs),
    .raddr2 (bus.rt),
    .rdata1 (rf_a),
    .rdata2 (rf_b),
    .we     (bus.regWrite),
    .waddr  (bus.writeReg),
    .wdata  (bus.writeData)
  );

  // Write-through: a same-edge writeback wins over the stale array value.
  always_comb begin
    byp_a   = bus.regWrite && (bus.writeReg != '0) && (bus.writeReg == bus.rs);
    byp_b   = bus.regWrite && (bus.writeReg != '0) && (bus.writeReg == bus.rt);
    op_a    = byp_a ? bus.writeData : rf_a;
    op_b    = byp_b ? bus.writeData : rf_b;
    imm_ext = {{(DATA_W-16){bus.imm16[15]}}, bus.imm16};
    mux_b   = bus.aluSrc ? imm_ext : op_b;
    dec     = alu_decode(aluop_e'(bus.aluOp), bus.imm16[5:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      bus.readData1     <= '0;
      bus.readData2     <= '0;
      bus.saidaMusReg   <= '0;
      bus.aluControlOut <= ALU_ADD;
      bus.opValid       <= 1'b0;
      bus.illegalOp     <= 1'b0;
    end else if (!bus.stall) begin
      bus.readData1     <= op_a;
      bus.readData2     <= op_b;
      bus.saidaMusReg   <= mux_b;
      bus.aluControlOut <= dec.code;
      bus.opValid       <= bus.instrValid;
      bus.illegalOp     <= bus.instrValid & dec.illegal;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage with hand-computed expected values.
module tb_operand_stage;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  operand_stage_if #(.DATA_W(32), .NREGS(32)) bus ();

  operand_stage #(.DATA_W(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] t,
                       input logic [15:0] imm, input logic [1:0] op, input logic src);
    bus.instrValid = v;
    bus.rs         = s;
    bus.rt         = t;
    bus.imm16      = imm;
    bus.aluOp      = op;
    bus.aluSrc     = src;
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    bus.regWrite  = we;
    bus.writeReg  = r;
    bus.writeData = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] m, input logic [3:0] c,
                           input logic v, input logic il);
    check({tag, ".rd1"},  bus.readData1,   a);
    check({tag, ".rd2"},  bus.readData2,   b);
    check({tag, ".muxb"}, bus.saidaMusReg, m);
    check({tag, ".ctrl"}, {28'd0, bus.aluControlOut}, {28'd0, c});
    check({tag, ".vld"},  {31'd0, bus.opValid},   {31'd0, v});
    check({tag, ".ill"},  {31'd0, bus.illegalOp}, {31'd0, il});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 2'b00, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    step();
    check_out("reset", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1: read after reset, R-type add
    drive(1'b1, 5'd5, 5'd6, 16'h0020, 2'b10, 1'b0);
    step();
    check_out("t1", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0);

    // 2: write then read, bypass on both ports, independent bypass
    drive(1'b0, 5'd0, 5'd0, 16'h0020, 2'b10, 1'b0);
    wb(1'b1, 5'd3, 32'h12345678);
    step();
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 5'd3, 5'd0, 16'h0020, 2'b10, 1'b0);
    step();
    check_out("t2rd", 32'h12345678, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0);
    wb(1'b1, 5'd7, 32'hDEADBEEF);
    drive(1'b1, 5'd7, 5'd7, 16'h0020, 2'b10, 1'b0);
    step();
    check_out("t2byp", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0010, 1'b1, 1'b0);
    wb(1'b1, 5'd8, 32'h0BADF00D);
    drive(1'b1, 5'd7, 5'd8, 16'h0020, 2'b10, 1'b0);
    step();
    check_out("t2bypb", 32'hDEADBEEF, 32'h0BADF00D, 32'h0BADF00D, 4'b0010, 1'b1, 1'b0);

    // 3: register 0 never written, never bypassed
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    drive(1'b1, 5'd0, 5'd0, 16'h0020, 2'b10, 1'b0);
    step();
    check_out("t3byp", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    step();
    check_out("t3rd", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0);

    // 4: decode and sign extension
    drive(1'b1, 5'd3, 5'd7, 16'h0000, 2'b01, 1'b0);
    step();
    check_out("t4beq", 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0110, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 16'h0024, 2'b10, 1'b0);
    step();
    check("t4and", {28'd0, bus.aluControlOut}, 32'h0);
    drive(1'b1, 5'd0, 5'd0, 16'h0025, 2'b10, 1'b0);
    step();
    check("t4or", {28'd0, bus.aluControlOut}, 32'h1);
    drive(1'b1, 5'd0, 5'd0, 16'h0022, 2'b10, 1'b0);
    step();
    check_out("t4sub", 32'h0, 32'h0, 32'h0, 4'b0110, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 16'h002A, 2'b10, 1'b0);
    step();
    check_out("t4slt", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 16'h0020, 2'b11, 1'b0);
    step();
    check_out("t4rsvd", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h002A, 2'b10, 1'b0);
    step();
    check_out("t4inv", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0);
    drive(1'b1, 5'd3, 5'd7, 16'h8000, 2'b00, 1'b1);
    step();
    check_out("t4sx", 32'h12345678, 32'hDEADBEEF, 32'hFFFF8000, 4'b0010, 1'b1, 1'b0);
    drive(1'b1, 5'd3, 5'd7, 16'h7FFF, 2'b00, 1'b1);
    step();
    check("t4zx", bus.saidaMusReg, 32'h00007FFF);

    // 5: capture A, stall 3 cycles with changing inputs and a write to rs
    drive(1'b1, 5'd3, 5'd7, 16'h0000, 2'b01, 1'b0);
    step();
    check_out("t5a", 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0110, 1'b1, 1'b0);
    bus.stall = 1'b1;
    wb(1'b1, 5'd3, 32'hAAAA5555);
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 5'(7 + i), 5'(3 + i), 16'h8024, 2'(2 + i), 1'b1);
      step();
      check_out($sformatf("t5st%0d", i), 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF,
                4'b0110, 1'b1, 1'b0);
    end
    wb(1'b0, 5'd0, 32'h0);
    bus.flush = 1'b1;
    drive(1'b1, 5'd3, 5'd7, 16'h0000, 2'b01, 1'b0);
    step();
    check_out("t5fl", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    step();
    check_out("t5post", 32'hAAAA5555, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0110, 1'b1, 1'b0);

    // 6: reset mid-operation with a pending write
    rst_n = 1'b0;
    wb(1'b1, 5'd9, 32'h00000055);
    step();
    check_out("t6rst", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0);
    rst_n = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 5'd9, 5'd3, 16'h0000, 2'b00, 1'b0);
    step();
    check_out("t6rd", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0);
    drive(1'b1, 5'd7, 5'd8, 16'h0000, 2'b00, 1'b0);
    step();
    check_out("t6rd2", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
